// File: rtl/fpu_div_pkg.sv
// Shared types and helpers for the floating-point divide adapter.
// Operand widths, tag entry layout, adapter state encoding.
package fpu_div_pkg;

    localparam int FPU_EXP_W = 8;
    localparam int FPU_MAN_W = 23;
    localparam int FPU_TAG_W = 4;

    typedef struct packed {
        logic                 dbz;
        logic [FPU_TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // True when exponent and mantissa are all zero; sign is ignored.
    function automatic logic is_zero(
        input logic [63:0] data,
        input int unsigned w
    );
        logic [63:0] mask;
        mask = (64'd1 << (w - 1)) - 64'd1;
        return ~|(data & mask);
    endfunction

endpackage

// File: rtl/fpu_div_axis_adapter_if.sv
// Bundle of operand, core and result streams around the divide adapter.
// slave is the adapter's view, master is the surrounding system's view.
interface fpu_div_axis_adapter_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 6
);
    import fpu_div_pkg::*;

    logic [DATA_W-1:0] s_axis_a_tdata;
    logic [TAG_W-1:0]  s_axis_a_tuser;
    logic              s_axis_a_tvalid;
    logic              s_axis_a_tready;
    logic [DATA_W-1:0] s_axis_b_tdata;
    logic              s_axis_b_tvalid;
    logic              s_axis_b_tready;
    logic [DATA_W-1:0] core_a_tdata;
    logic [DATA_W-1:0] core_b_tdata;
    logic              core_ab_tvalid;
    logic [DATA_W-1:0] core_result_tdata;
    logic              core_result_tvalid;
    logic [DATA_W-1:0] m_axis_result_tdata;
    logic [TAG_W:0]    m_axis_result_tuser;
    logic              m_axis_result_tvalid;
    logic              m_axis_result_tready;
    logic [CNT_W-1:0]  inflight;
    logic              proto_err;

    modport slave (
        input  s_axis_a_tdata, s_axis_a_tuser, s_axis_a_tvalid,
        input  s_axis_b_tdata, s_axis_b_tvalid,
        input  core_result_tdata, core_result_tvalid,
        input  m_axis_result_tready,
        output s_axis_a_tready, s_axis_b_tready,
        output core_a_tdata, core_b_tdata, core_ab_tvalid,
        output m_axis_result_tdata, m_axis_result_tuser,
        output m_axis_result_tvalid,
        output inflight, proto_err
    );

    modport master (
        output s_axis_a_tdata, s_axis_a_tuser, s_axis_a_tvalid,
        output s_axis_b_tdata, s_axis_b_tvalid,
        output core_result_tdata, core_result_tvalid,
        output m_axis_result_tready,
        input  s_axis_a_tready, s_axis_b_tready,
        input  core_a_tdata, core_b_tdata, core_ab_tvalid,
        input  m_axis_result_tdata, m_axis_result_tuser,
        input  m_axis_result_tvalid,
        input  inflight, proto_err
    );

endinterface

// File: rtl/fpu_div_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy count.
// Pointers wrap at DEPTH so non-power-of-two depths work.
module fpu_div_sync_fifo
    import fpu_div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fpu_div_axis_adapter.sv
// AXI-Stream front end for a fixed-latency, non-stallable divide core.
// Credits bound outstanding work so core results always have a slot.
module fpu_div_axis_adapter
    import fpu_div_pkg::*;
#(
    parameter int EXP_W      = FPU_EXP_W,
    parameter int MAN_W      = FPU_MAN_W,
    parameter int TAG_W      = 4,
    parameter int LATENCY    = 28,
    parameter int FIFO_DEPTH = 32
) (
    input logic                  aclk,
    input logic                  areset,
    fpu_div_axis_adapter_if.slave bus
);

    localparam int DATA_W = 1 + EXP_W + MAN_W;
    localparam int TE_W   = TAG_W + 1;
    localparam int RES_W  = DATA_W + TE_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int DRN_W  = $clog2(LATENCY + 2);

    localparam logic [0:0] DRAIN = ST_DRAIN;
    localparam logic [0:0] RUN   = ST_RUN;

    typedef struct packed {
        logic             dbz;
        logic [TAG_W-1:0] tag;
    } tag_ent_t;

    logic [0:0]       state;
    logic [DRN_W-1:0] drain_cnt;
    logic [CNT_W-1:0] credits;
    logic [CNT_W-1:0] inflight;
    logic             run;
    logic             has_credit;
    logic             fire;
    logic             m_hs;
    logic             res_in;

    tag_ent_t         tag_wdata;
    tag_ent_t         tag_head;
    logic             tag_full;
    logic             tag_empty;
    logic [CNT_W-1:0] tag_count;

    logic [RES_W-1:0] res_rdata;
    logic             res_push;
    logic             res_full;
    logic             res_empty;
    logic [CNT_W-1:0] res_count;

    assign run        = (state == RUN);
    assign has_credit = (credits != '0);
    assign fire       = run & has_credit
                      & bus.s_axis_a_tvalid & bus.s_axis_b_tvalid;
    assign m_hs       = bus.m_axis_result_tvalid
                      & bus.m_axis_result_tready;
    assign res_in     = run & bus.core_result_tvalid;
    assign res_push   = res_in & ~tag_empty;
    assign inflight   = CNT_W'(FIFO_DEPTH) - credits;

    assign bus.s_axis_a_tready = run & has_credit & bus.s_axis_b_tvalid;
    assign bus.s_axis_b_tready = run & has_credit & bus.s_axis_a_tvalid;
    assign bus.inflight        = inflight;

    assign tag_wdata.dbz = is_zero(64'(bus.s_axis_b_tdata), DATA_W);
    assign tag_wdata.tag = bus.s_axis_a_tuser;

    // Hold off operand acceptance until stale core results have drained.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= DRAIN;
            drain_cnt <= DRN_W'(LATENCY + 1);
        end else if (state == DRAIN) begin
            if (drain_cnt == '0) begin
                state <= RUN;
            end else begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end

    // Register operands toward the core with a single-cycle valid.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bus.core_a_tdata   <= '0;
            bus.core_b_tdata   <= '0;
            bus.core_ab_tvalid <= 1'b0;
        end else begin
            bus.core_ab_tvalid <= fire;
            if (fire) begin
                bus.core_a_tdata <= bus.s_axis_a_tdata;
                bus.core_b_tdata <= bus.s_axis_b_tdata;
            end
        end
    end

    // One credit per result slot; returned when the result leaves.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            credits <= CNT_W'(FIFO_DEPTH);
        end else begin
            case ({fire, m_hs})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: ;
            endcase
        end
    end

    // Latch a core result that arrives with no matching tag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bus.proto_err <= 1'b0;
        end else if (res_in && tag_empty) begin
            bus.proto_err <= 1'b1;
        end
    end

    fpu_div_sync_fifo #(
        .WIDTH (TE_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_W)
    ) u_tag_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (fire),
        .wdata (tag_wdata),
        .pop   (res_push),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    fpu_div_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_W)
    ) u_res_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (res_push),
        .wdata ({bus.core_result_tdata, tag_head}),
        .pop   (m_hs),
        .rdata (res_rdata),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    assign bus.m_axis_result_tvalid = ~res_empty;
    assign bus.m_axis_result_tdata  = res_rdata[TE_W +: DATA_W];
    assign bus.m_axis_result_tuser  = res_rdata[TE_W-1:0];

    a_res_no_overflow : assert property (
        @(posedge aclk) disable iff (areset)
        !(res_push && res_full)
    );

    a_tag_no_overflow : assert property (
        @(posedge aclk) disable iff (areset)
        !(fire && tag_full)
    );

    a_credit_balance : assert property (
        @(posedge aclk) disable iff (areset)
        ({1'b0, tag_count} + {1'b0, res_count}) == {1'b0, inflight}
    );

endmodule
